// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Instruction-cycle state machine feeding the control LUT. An instruction byte
//   is accepted over a valid/ready handshake into the instruction register (IR).
//   The sequencer then steps FETCH -> DECODE -> EXECUTE -> WRITEBACK -> OUTPUT and
//   presents {instruction, state} to the LUT. NOP returns after EXECUTE, LOAD
//   returns after WRITEBACK, and every other instruction waits in OUTPUT until the
//   downstream consumer takes the result.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high (wins over ena)
//   ena          in   global enable; 0 freezes every register
//   halt         in   blocks acceptance of a new instruction while in FETCH
//   instr_in     in   incoming instruction byte
//   instr_valid  in   instr_in is valid
//   instr_ready  out  sequencer can accept instr_in this cycle
//   instruction  out  latched IR
//   state        out  cycle state (FETCH=0 .. OUTPUT=4)
//   out_valid    out  OUTPUT-phase result available (registered)
//   out_ready    in   consumer accepts the result
//   busy         out  state != FETCH
//   retired      out  count of completed instructions, wraps
module cpu_sequencer #(
  parameter logic [3:0] LOAD_OPCODE = 4'hA,
  parameter logic [7:0] NOP_INSTR   = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             halt,
  input  logic [7:0]       instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [7:0]       instruction,
  output logic [2:0]       state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH     = 3'b000,
    DECODE    = 3'b001,
    EXECUTE   = 3'b010,
    WRITEBACK = 3'b011,
    OUTPUT    = 3'b100
  } state_t;

  // The state register is a plain 3-bit vector rather than state_t so that the
  // unused codes 101..111 are representable and can be recovered from.
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [7:0]       ir_q;
  logic [7:0]       ir_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             accept;

  assign instr_ready = ena & ~halt & (state_q == FETCH);
  assign accept      = instr_valid & instr_ready;
  assign busy        = (state_q != FETCH);
  assign state       = state_q;
  assign instruction = ir_q;
  assign out_valid   = out_valid_q;
  assign retired     = retired_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (accept) begin
          ir_d    = instr_in;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        if (ir_q == NOP_INSTR) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        if (ir_q[3:0] == LOAD_OPCODE) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      // Illegal codes fall back to FETCH without retiring; IR is left alone.
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      ir_q        <= 8'h00;
      out_valid_q <= 1'b0;
      retired_q   <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      // Registered result flag: high exactly while the machine sits in OUTPUT.
      out_valid_q <= (state_d == OUTPUT);
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed stimulus, a queue-based reference model of
// the instruction phases, a per-cycle compare process, and literal spot checks.
module tb_cpu_sequencer;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          halt;
  logic [7:0]    instr_in;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instruction;
  logic [2:0]    state;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic [CW-1:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  cpu_sequencer #(.LOAD_OPCODE(4'hA), .NOP_INSTR(8'h00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .halt(halt),
    .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .state(state), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance the instruction's whole phase list is
  // written into a queue, and each enabled cycle consumes one entry. OUTPUT is
  // held until the consumer is ready.
  int         m_state = 0;
  int         m_rem[$];
  logic [7:0] m_ir = 8'h00;
  int         m_ret = 0;
  bit         m_ov = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_rem.delete(); m_ir = 8'h00; m_ret = 0; m_ov = 0;
    end else if (ena) begin
      if (m_state == 0) begin
        if (instr_valid && !halt) begin
          m_ir = instr_in;
          m_rem.delete();
          m_rem.push_back(1);
          m_rem.push_back(2);
          if (instr_in != 8'h00) m_rem.push_back(3);
          if (instr_in != 8'h00 && instr_in[3:0] != 4'hA) m_rem.push_back(4);
          m_state = m_rem.pop_front();
        end
      end else if (m_state > 4) begin
        m_state = 0;
      end else if (m_state == 4) begin
        if (out_ready) begin
          m_state = 0;
          m_ret = (m_ret + 1) % (1 << CW);
        end
      end else if (m_rem.size() == 0) begin
        m_state = 0;
        m_ret = (m_ret + 1) % (1 << CW);
      end else begin
        m_state = m_rem.pop_front();
      end
      m_ov = (m_state == 4);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_state", 32'(state), 32'(m_state));
      chk("cmp_instruction", 32'(instruction), 32'(m_ir));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
      chk("cmp_busy", 32'(busy), 32'(m_state != 0));
      chk("cmp_instr_ready", 32'(instr_ready), 32'(ena && !halt && m_state == 0));
      chk("cmp_retired", 32'(retired), 32'(m_ret));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int add_seq[5]  = '{1, 2, 3, 4, 0};
  int load_seq[4] = '{1, 2, 3, 0};
  int nop_seq[3]  = '{1, 2, 0};

  initial begin
    rst = 1'b1; ena = 1'b1; halt = 1'b0; instr_in = 8'h00;
    instr_valid = 1'b0; out_ready = 1'b0;

    // Reset for two cycles
    cyc();
    chk_on = 1;
    cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_instruction", 32'(instruction), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_instr_ready", 32'(instr_ready), 1);
    rst = 1'b0;

    // ADD R-type, consumer always ready
    instr_in = 8'h41; instr_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      instr_valid = 1'b0;
      chk("add_state", 32'(state), 32'(add_seq[i]));
      if (i == 3) chk("add_out_valid", 32'(out_valid), 1);
    end
    chk("add_retired", 32'(retired), 1);
    chk("add_instruction", 32'(instruction), 32'h41);

    // LOAD skips OUTPUT
    instr_in = 8'h1A; instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      instr_valid = 1'b0;
      chk("load_state", 32'(state), 32'(load_seq[i]));
      chk("load_out_valid", 32'(out_valid), 0);
    end
    chk("load_retired", 32'(retired), 2);

    // NOP skips WRITEBACK and OUTPUT
    instr_in = 8'h00; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      instr_valid = 1'b0;
      chk("nop_state", 32'(state), 32'(nop_seq[i]));
    end
    chk("nop_retired", 32'(retired), 3);

    // Halt blocks acceptance
    halt = 1'b1; instr_in = 8'h55; instr_valid = 1'b1;
    repeat (3) cyc();
    chk("halt_state", 32'(state), 0);
    chk("halt_instruction", 32'(instruction), 0);
    chk("halt_instr_ready", 32'(instr_ready), 0);
    chk("halt_retired", 32'(retired), 3);
    halt = 1'b0;

    // Backpressure in OUTPUT, then freeze, then reset
    instr_in = 8'h23; out_ready = 1'b0;
    cyc();
    instr_valid = 1'b1;
    instr_in = 8'h77;
    repeat (8) cyc();
    chk("bp_state", 32'(state), 4);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_instruction", 32'(instruction), 32'h23);
    ena = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("frz_state", 32'(state), 4);
    chk("frz_out_valid", 32'(out_valid), 1);
    chk("frz_instr_ready", 32'(instr_ready), 0);
    chk("frz_retired", 32'(retired), 3);
    rst = 1'b1; instr_valid = 1'b0;
    cyc();
    chk("rst2_state", 32'(state), 0);
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_retired", 32'(retired), 0);
    rst = 1'b0; ena = 1'b1;

    // Back-to-back NOPs: 16 retires wrap the 4-bit counter
    instr_in = 8'h00; instr_valid = 1'b1;
    repeat (45) cyc();
    chk("wrap_retired_15", 32'(retired), 15);
    repeat (3) cyc();
    instr_valid = 1'b0;
    chk("wrap_retired_0", 32'(retired), 0);
    chk("wrap_state", 32'(state), 0);

    // Non-NOP with zero low nibble, and high-nibble LOAD; halt mid-flight
    instr_in = 8'h10; instr_valid = 1'b1; out_ready = 1'b0;
    cyc();
    instr_valid = 1'b0; halt = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b1;
    cyc();
    chk("h10_state", 32'(state), 0);
    chk("h10_retired", 32'(retired), 1);
    halt = 1'b0;
    instr_in = 8'hFA; instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    repeat (3) cyc();
    chk("hfa_retired", 32'(retired), 2);

    // Illegal state recovers to FETCH without retiring
    force dut.state_q = 3'b101;
    m_state = 5;
    @(negedge clk);
    #1;
    release dut.state_q;
    cyc();
    chk("ill_state", 32'(state), 0);
    chk("ill_retired", 32'(retired), 2);
    chk("ill_instruction", 32'(instruction), 32'hFA);

    repeat (2) cyc();
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
